// File: rtl/lcd_writer_pkg.sv
// Shared types and constants for the result LCD writer and its BCD converter.
package lcd_writer_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StConv,
        StWaitRdy,
        StSetup,
        StPulse,
        StGap,
        StDone
    } state_e;

    typedef logic [3:0] bcd_digit_t;

    localparam logic [7:0]  ASCII_ZERO  = 8'h30;
    localparam logic [7:0]  ASCII_SPACE = 8'h20;
    localparam logic [7:0]  CMD_DDRAM_L1 = 8'h80;
    localparam int unsigned N_BYTES     = 6;
    localparam int          N_DIGITS    = 5;

    // Character for byte idx 1..5 (msd..lsd); a zero digit is blanked only while every
    // more-significant digit is also zero, and the lsd is never blanked.
    function automatic logic [7:0] digit_char(input logic [2:0]  idx,
                                              input logic [19:0] bcd,
                                              input logic        blank_en);
        bcd_digit_t d;
        logic       lead;
        logic [7:0] ch;
        lead = 1'b1;
        ch   = ASCII_ZERO;
        for (int k = 1; k <= N_DIGITS; k++) begin
            d = bcd[20 - 4*k +: 4];
            if (d != 4'd0) lead = 1'b0;
            if (idx == 3'(k)) begin
                ch = (blank_en && lead && k != N_DIGITS) ? ASCII_SPACE
                                                         : (ASCII_ZERO | {4'h0, d});
            end
        end
        return ch;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 16-bit double-dabble: one shift/add-3 step per cycle, valid pulses after 16 steps.
module bin2bcd_seq
    import lcd_writer_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] bin,
    output logic        busy,
    output logic        valid,
    output logic [19:0] bcd
);

    logic [15:0] shift_q;
    logic [19:0] work_q;
    logic [19:0] work_d;
    logic [19:0] adj;
    logic [3:0]  step_q;
    bcd_digit_t  dig;

    always_comb begin
        adj = work_q;
        dig = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            dig = adj[4*i +: 4];
            if (dig > 4'd4) adj[4*i +: 4] = dig + 4'd3;
        end
        work_d = {adj[18:0], shift_q[15]};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_q <= '0;
            work_q  <= '0;
            step_q  <= '0;
            busy    <= 1'b0;
            valid   <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (load && !busy) begin
                shift_q <= bin;
                work_q  <= '0;
                step_q  <= '0;
                busy    <= 1'b1;
            end else if (busy) begin
                shift_q <= {shift_q[14:0], 1'b0};
                work_q  <= work_d;
                step_q  <= step_q + 4'd1;
                if (step_q == 4'd15) begin
                    busy  <= 1'b0;
                    valid <= 1'b1;
                end
            end
        end
    end

    assign bcd = work_q;

endmodule

// File: rtl/result_lcd_writer.sv
// Captures a 16-bit result, converts to BCD and writes address + 5 characters to an HD44780 LCD.
// Define LCD_LEADING_BLANK_EN to send leading zero digits as spaces.
module result_lcd_writer
    import lcd_writer_pkg::*;
#(
    parameter int unsigned SETUP_CYC   = 2,
    parameter int unsigned E_PULSE_CYC = 12,
    parameter int unsigned GAP_CYC     = 2000,
    parameter logic [7:0]  LCD_ADDR    = CMD_DDRAM_L1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [15:0] value_i,
    input  logic        lcd_ready_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [19:0] bcd_o,
    output logic [7:0]  lcd_data_o,
    output logic        lcd_rs_o,
    output logic        lcd_rw_o,
    output logic        lcd_e_o
);

`ifdef LCD_LEADING_BLANK_EN
    localparam logic BLANK_EN = 1'b1;
`else
    localparam logic BLANK_EN = 1'b0;
`endif

    localparam int unsigned MAX_SP  = (SETUP_CYC > E_PULSE_CYC) ? SETUP_CYC : E_PULSE_CYC;
    localparam int unsigned MAX_CYC = (MAX_SP > GAP_CYC) ? MAX_SP : GAP_CYC;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [2:0]         idx_q;
    logic               conv_busy;
    logic               conv_valid;
    logic [19:0]        conv_bcd;

    // Converter loads straight from value_i on the accepted start, so it doubles as the capture.
    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .load  (state_q == StIdle && start_i),
        .bin   (value_i),
        .busy  (conv_busy),
        .valid (conv_valid),
        .bcd   (conv_bcd)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            idx_q      <= '0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            bcd_o      <= '0;
            lcd_data_o <= '0;
            lcd_rs_o   <= 1'b0;
            lcd_e_o    <= 1'b0;
        end else begin
            done_o <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        busy_o  <= 1'b1;
                        state_q <= StConv;
                    end
                end
                StConv: begin
                    if (conv_valid && !conv_busy) begin
                        bcd_o      <= conv_bcd;
                        idx_q      <= '0;
                        cnt_q      <= '0;
                        lcd_data_o <= LCD_ADDR;
                        lcd_rs_o   <= 1'b0;
                        state_q    <= lcd_ready_i ? StSetup : StWaitRdy;
                    end
                end
                StWaitRdy: begin
                    if (lcd_ready_i) state_q <= StSetup;
                end
                StSetup: begin
                    if (cnt_q == CNT_W'(SETUP_CYC - 1)) begin
                        cnt_q   <= '0;
                        lcd_e_o <= 1'b1;
                        state_q <= StPulse;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                StPulse: begin
                    if (cnt_q == CNT_W'(E_PULSE_CYC - 1)) begin
                        cnt_q   <= '0;
                        lcd_e_o <= 1'b0;
                        state_q <= StGap;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                StGap: begin
                    if (cnt_q == CNT_W'(GAP_CYC - 1)) begin
                        cnt_q <= '0;
                        if (idx_q == 3'(N_BYTES - 1)) begin
                            done_o  <= 1'b1;
                            busy_o  <= 1'b0;
                            state_q <= StDone;
                        end else begin
                            idx_q      <= idx_q + 3'd1;
                            lcd_data_o <= digit_char(idx_q + 3'd1, bcd_o, BLANK_EN);
                            lcd_rs_o   <= 1'b1;
                            state_q    <= StSetup;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign lcd_rw_o = 1'b0;

endmodule

// File: tb/tb_result_lcd_writer.sv
// Scoreboard bench for result_lcd_writer with short LCD timing (setup 2, pulse 3, gap 4).
module tb_result_lcd_writer;

    localparam int unsigned SETUP_CYC   = 2;
    localparam int unsigned E_PULSE_CYC = 3;
    localparam int unsigned GAP_CYC     = 4;
    localparam int          FIRST_E_LAT = 19;
    localparam int          DONE_LAT    = 71;

`ifdef LCD_LEADING_BLANK_EN
    localparam logic [47:0] EXP_256  = 48'h80_20_20_32_35_36;
    localparam logic [47:0] EXP_0    = 48'h80_20_20_20_20_30;
    localparam logic [47:0] EXP_1234 = 48'h80_20_31_32_33_34;
    localparam logic [47:0] EXP_7    = 48'h80_20_20_20_20_37;
`else
    localparam logic [47:0] EXP_256  = 48'h80_30_30_32_35_36;
    localparam logic [47:0] EXP_0    = 48'h80_30_30_30_30_30;
    localparam logic [47:0] EXP_1234 = 48'h80_30_31_32_33_34;
    localparam logic [47:0] EXP_7    = 48'h80_30_30_30_30_37;
`endif
    localparam logic [47:0] EXP_65535 = 48'h80_36_35_35_33_35;
    localparam logic [47:0] EXP_40000 = 48'h80_34_30_30_30_30;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic [15:0] value_i;
    logic        lcd_ready_i;
    logic        busy_o;
    logic        done_o;
    logic [19:0] bcd_o;
    logic [7:0]  lcd_data_o;
    logic        lcd_rs_o;
    logic        lcd_rw_o;
    logic        lcd_e_o;

    typedef struct {
        logic [8:0] b;
        int         lat;
    } exp_byte_t;

    typedef struct {
        logic [19:0] bcd;
        int          lat;
    } exp_done_t;

    exp_byte_t exp_bytes[$];
    exp_done_t exp_done[$];

    int checks = 0;
    int passed = 0;
    int cyc = 0;
    int t_start = 0;
    logic prev_e = 1'b0;

    result_lcd_writer #(
        .SETUP_CYC   (SETUP_CYC),
        .E_PULSE_CYC (E_PULSE_CYC),
        .GAP_CYC     (GAP_CYC),
        .LCD_ADDR    (8'h80)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .value_i     (value_i),
        .lcd_ready_i (lcd_ready_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .bcd_o       (bcd_o),
        .lcd_data_o  (lcd_data_o),
        .lcd_rs_o    (lcd_rs_o),
        .lcd_rw_o    (lcd_rw_o),
        .lcd_e_o     (lcd_e_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Monitor: every rising E and every done pulse is matched against the scoreboard.
    always @(negedge clk) begin
        exp_byte_t eb;
        exp_done_t ed;
        if (!rst) begin
            prev_e = 1'b0;
        end else begin
            if (lcd_e_o && !prev_e) begin
                if (exp_bytes.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_byte: got %0h, expected no byte", lcd_data_o);
                end else begin
                    eb = exp_bytes.pop_front();
                    check("lcd_byte", {23'd0, lcd_rs_o, lcd_data_o}, {23'd0, eb.b});
                    if (eb.lat >= 0) check("first_e_latency", cyc - t_start - 1, eb.lat);
                end
            end
            prev_e = lcd_e_o;
            if (done_o) begin
                if (exp_done.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_done: got done, expected none");
                end else begin
                    ed = exp_done.pop_front();
                    check("done_bcd", {12'd0, bcd_o}, {12'd0, ed.bcd});
                    check("done_latency", cyc - t_start - 1, ed.lat);
                    check("busy_at_done", {31'd0, busy_o}, 32'd0);
                end
            end
        end
    end

    task automatic push_txn(input logic [47:0] bytes, input logic [19:0] bcd, input int delay);
        exp_byte_t eb;
        exp_done_t ed;
        for (int i = 0; i < 6; i++) begin
            eb.b   = {(i != 0), bytes[47 - 8*i -: 8]};
            eb.lat = (i == 0) ? FIRST_E_LAT + delay : -1;
            exp_bytes.push_back(eb);
        end
        ed.bcd = bcd;
        ed.lat = DONE_LAT + delay;
        exp_done.push_back(ed);
    endtask

    task automatic pulse_start(input logic [15:0] v);
        @(negedge clk);
        value_i = v;
        start_i = 1'b1;
        t_start = cyc;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            if (!busy_o) break;
            @(negedge clk);
        end
        if (i == budget) begin
            checks++;
            $display("FAIL wait_idle_timeout: got busy after %0d cycles, expected idle", budget);
        end
    endtask

    task automatic wait_e_high(input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk);
            if (lcd_e_o) break;
        end
        if (i == budget) begin
            checks++;
            $display("FAIL wait_e_timeout: got no E after %0d cycles, expected E", budget);
        end
    endtask

    task automatic run_txn(input logic [15:0] v, input logic [47:0] bytes,
                           input logic [19:0] bcd, input int delay);
        push_txn(bytes, bcd, delay);
        if (delay > 0) lcd_ready_i = 1'b0;
        pulse_start(v);
        if (delay > 0) begin
            repeat (16 + delay) @(negedge clk);
            lcd_ready_i = 1'b1;
        end
        wait_idle(200 + delay);
    endtask

    initial begin
        exp_byte_t eb;
        rst         = 1'b0;
        start_i     = 1'b0;
        value_i     = '0;
        lcd_ready_i = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_done", {31'd0, done_o}, 32'd0);
        check("rst_bcd", {12'd0, bcd_o}, 32'd0);
        check("rst_data", {24'd0, lcd_data_o}, 32'd0);
        check("rst_rs", {31'd0, lcd_rs_o}, 32'd0);
        check("rst_rw", {31'd0, lcd_rw_o}, 32'd0);
        check("rst_e", {31'd0, lcd_e_o}, 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        run_txn(16'd65535, EXP_65535, 20'h65535, 0);
        run_txn(16'd256, EXP_256, 20'h00256, 0);
        run_txn(16'd0, EXP_0, 20'h00000, 0);
        run_txn(16'd1234, EXP_1234, 20'h01234, 20);

        // Starts during PULSE and on the done cycle must both be ignored.
        push_txn(EXP_40000, 20'h40000, 0);
        pulse_start(16'd40000);
        wait_e_high(100);
        value_i = 16'd111;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        wait_idle(200);
        value_i = 16'd222;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (40) @(negedge clk);
        check("busy_after_ignored_start", {31'd0, busy_o}, 32'd0);
        check("bcd_after_ignored_start", {12'd0, bcd_o}, {12'd0, 20'h40000});

        // Reset in the middle of the first byte's E pulse.
        eb.b   = 9'h080;
        eb.lat = FIRST_E_LAT;
        exp_bytes.push_back(eb);
        pulse_start(16'd4321);
        wait_e_high(100);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_e", {31'd0, lcd_e_o}, 32'd0);
        check("midrst_busy", {31'd0, busy_o}, 32'd0);
        check("midrst_data", {24'd0, lcd_data_o}, 32'd0);
        check("midrst_done", {31'd0, done_o}, 32'd0);
        exp_bytes.delete();
        exp_done.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        run_txn(16'd7, EXP_7, 20'h00007, 0);

        repeat (20) @(negedge clk);
        check("leftover_bytes", exp_bytes.size(), 32'd0);
        check("leftover_done", exp_done.size(), 32'd0);
        check("rw_constant", {31'd0, lcd_rw_o}, 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish within 200000 time units");
        $fatal(1, "timeout");
    end

endmodule
